// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control bus between the multicycle controller and the RV32I datapath
interface multicycle_controller_if;
    // IR fields and ALU flags coming back from the datapath
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       LessThan;

    // mux selects and write enables going out to the datapath
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;

    // controller side
    modport master (
        input  op, funct3, funct7, Zero, LessThan,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc
    );

    // datapath side
    modport slave (
        output op, funct3, funct7, Zero, LessThan,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multi-cycle RV32I core
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_controller_if.master ctrl,
    output logic                 Illegal,
    output logic [3:0]           State,
    output logic [CNT_W-1:0]     InstrCount
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        JALR     = 4'd10,
        JALR2    = 4'd11,
        BRANCH   = 4'd12,
        LUI      = 4'd13,
        SPARE    = 4'd14,
        ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [2:0] AluAdd  = 3'b000;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluAnd  = 3'b010;
    localparam logic [2:0] AluOr   = 3'b011;
    localparam logic [2:0] AluSltu = 3'b100;
    localparam logic [2:0] AluSlt  = 3'b101;
    localparam logic [2:0] AluXor  = 3'b110;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;
    localparam logic [1:0] ResImmExt    = 2'b11;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;

    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [CNT_W-1:0] CntOne = 1;

    state_t stateReg;
    state_t nextState;

    // raw enables before reset gating
    logic pcWriteRaw;
    logic memWriteRaw;
    logic irWriteRaw;
    logic regWriteRaw;

    // funct decode results
    logic [2:0] rAluCtl;
    logic       rLegal;
    logic [2:0] iAluCtl;
    logic       iLegal;
    logic       brTaken;
    logic       brLegal;

    // decode funct fields into ALU operations, legality and branch outcome
    always_comb begin
        rAluCtl = AluAdd;
        rLegal  = 1'b1;
        if (ctrl.funct7 == 7'b0100000) begin
            rAluCtl = AluSub;
        end else begin
            case (ctrl.funct3)
                3'b000:  rAluCtl = AluAdd;
                3'b111:  rAluCtl = AluAnd;
                3'b110:  rAluCtl = AluOr;
                3'b010:  rAluCtl = AluSlt;
                3'b011:  rAluCtl = AluSltu;
                default: rLegal  = 1'b0;
            endcase
        end

        iAluCtl = AluAdd;
        iLegal  = 1'b1;
        case (ctrl.funct3)
            3'b000:  iAluCtl = AluAdd;
            3'b100:  iAluCtl = AluXor;
            3'b110:  iAluCtl = AluOr;
            3'b010:  iAluCtl = AluSlt;
            3'b011:  iAluCtl = AluSltu;
            default: iLegal  = 1'b0;
        endcase

        brTaken = 1'b0;
        brLegal = 1'b1;
        case (ctrl.funct3)
            3'b000:  brTaken = ctrl.Zero;
            3'b001:  brTaken = ~ctrl.Zero;
            3'b100:  brTaken = ctrl.LessThan;
            3'b101:  brTaken = ~ctrl.LessThan;
            default: brLegal = 1'b0;
        endcase
    end

    // next state and per-state control outputs; branch PCWrite must follow
    // the live Zero/LessThan flags, so selects are decoded from the state register
    always_comb begin
        nextState       = stateReg;
        pcWriteRaw      = 1'b0;
        memWriteRaw     = 1'b0;
        irWriteRaw      = 1'b0;
        regWriteRaw     = 1'b0;
        ctrl.AdrSrc     = 1'b0;
        ctrl.ResultSrc  = ResAluOut;
        ctrl.ALUSrcA    = SrcAPc;
        ctrl.ALUSrcB    = SrcBRd2;
        ctrl.ALUControl = AluAdd;
        ctrl.ImmSrc     = ImmI;

        case (stateReg)
            FETCH: begin
                ctrl.AdrSrc    = 1'b0;
                irWriteRaw     = 1'b1;
                ctrl.ALUSrcA   = SrcAPc;
                ctrl.ALUSrcB   = SrcBFour;
                ctrl.ResultSrc = ResAluResult;
                pcWriteRaw     = 1'b1;
                nextState      = DECODE;
            end
            DECODE: begin
                ctrl.ALUSrcA = SrcAOldPc;
                ctrl.ALUSrcB = SrcBImm;
                ctrl.ImmSrc  = (ctrl.op == OpBranch) ? ImmB : ImmJ;
                case (ctrl.op)
                    OpLoad, OpStore: nextState = MEMADR;
                    OpRType:         nextState = EXECUTER;
                    OpIAlu:          nextState = EXECUTEI;
                    OpJal:           nextState = JAL;
                    OpJalr:          nextState = JALR;
                    OpBranch:        nextState = BRANCH;
                    OpLui:           nextState = LUI;
                    default:         nextState = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ctrl.ALUSrcA = SrcARd1;
                ctrl.ALUSrcB = SrcBImm;
                ctrl.ImmSrc  = (ctrl.op == OpStore) ? ImmS : ImmI;
                nextState    = (ctrl.op == OpStore) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                ctrl.AdrSrc    = 1'b1;
                ctrl.ResultSrc = ResAluOut;
                nextState      = MEMWB;
            end
            MEMWB: begin
                ctrl.ResultSrc = ResData;
                regWriteRaw    = 1'b1;
                nextState      = FETCH;
            end
            MEMWRITE: begin
                ctrl.AdrSrc    = 1'b1;
                ctrl.ResultSrc = ResAluOut;
                memWriteRaw    = 1'b1;
                nextState      = FETCH;
            end
            EXECUTER: begin
                ctrl.ALUSrcA    = SrcARd1;
                ctrl.ALUSrcB    = SrcBRd2;
                ctrl.ALUControl = rAluCtl;
                nextState       = rLegal ? ALUWB : ILLEGAL;
            end
            EXECUTEI: begin
                ctrl.ALUSrcA    = SrcARd1;
                ctrl.ALUSrcB    = SrcBImm;
                ctrl.ImmSrc     = ImmI;
                ctrl.ALUControl = iAluCtl;
                nextState       = iLegal ? ALUWB : ILLEGAL;
            end
            ALUWB: begin
                ctrl.ResultSrc = ResAluOut;
                regWriteRaw    = 1'b1;
                nextState      = FETCH;
            end
            JAL, JALR2: begin
                // PC takes the jump target held in ALUOut while the ALU forms OldPC+4
                ctrl.ALUSrcA   = SrcAOldPc;
                ctrl.ALUSrcB   = SrcBFour;
                ctrl.ResultSrc = ResAluOut;
                pcWriteRaw     = 1'b1;
                nextState      = ALUWB;
            end
            JALR: begin
                ctrl.ALUSrcA = SrcARd1;
                ctrl.ALUSrcB = SrcBImm;
                ctrl.ImmSrc  = ImmI;
                nextState    = JALR2;
            end
            BRANCH: begin
                ctrl.ALUSrcA    = SrcARd1;
                ctrl.ALUSrcB    = SrcBRd2;
                ctrl.ALUControl = AluSub;
                ctrl.ResultSrc  = ResAluOut;
                pcWriteRaw      = brLegal & brTaken;
                nextState       = brLegal ? FETCH : ILLEGAL;
            end
            LUI: begin
                ctrl.ImmSrc    = ImmU;
                ctrl.ResultSrc = ResImmExt;
                regWriteRaw    = 1'b1;
                nextState      = FETCH;
            end
            ILLEGAL: begin
                nextState = ILLEGAL;
            end
            default: begin
                // the unused encoding is treated as a trap, same as ILLEGAL
                nextState = ILLEGAL;
            end
        endcase
    end

    // an instruction aborted by reset must not commit anything in its last cycle
    always_comb begin
        ctrl.PCWrite  = pcWriteRaw  & ~rst;
        ctrl.MemWrite = memWriteRaw & ~rst;
        ctrl.IRWrite  = irWriteRaw  & ~rst;
        ctrl.RegWrite = regWriteRaw & ~rst;
    end

    // state register, retired-instruction counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= FETCH;
            InstrCount <= '0;
            Illegal    <= 1'b0;
        end else begin
            stateReg <= nextState;
            // FETCH always leaves to DECODE, so a FETCH next state means retirement
            if (nextState == FETCH) begin
                InstrCount <= InstrCount + CntOne;
            end
            Illegal <= (nextState == ILLEGAL);
        end
    end

    assign State = stateReg;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    logic             clk;
    logic             rst;
    logic             Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    int checks;
    int failures;
    int expCount;

    multicycle_controller_if bus();

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl       (bus.master),
        .Illegal    (Illegal),
        .State      (State),
        .InstrCount (InstrCount)
    );

    // free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog so the run can never hang
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reset from a known current state; enables must drop in the reset cycle
    task automatic doReset(input int curState);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cur_state", {28'd0, State}, curState);
        check("rst_pcwrite", {31'd0, bus.PCWrite}, 0);
        check("rst_irwrite", {31'd0, bus.IRWrite}, 0);
        check("rst_regwrite", {31'd0, bus.RegWrite}, 0);
        check("rst_memwrite", {31'd0, bus.MemWrite}, 0);
        @(posedge clk);
        #1;
        check("rst_state", {28'd0, State}, 0);
        check("rst_count", {28'd0, InstrCount}, 0);
        check("rst_illegal", {31'd0, Illegal}, 0);
        rst = 1'b0;
        expCount = 0;
    endtask

    // run one instruction from FETCH and check every cycle against the model;
    // abortStep >= 0 asserts reset at that step of the instruction
    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic zero, input logic lt, input int abortStep);
        int p[5];
        int n;
        int pcStep;
        int wbStep;
        int memStep;
        int exStep;
        logic [1:0] wbSrc;
        logic [2:0] expAlu;
        bit isSw;
        bit aluOk;
        bit expIr;
        bit expPc;
        bit expReg;
        bit expMem;
        bit expAdr;
        pcStep  = -1;
        wbStep  = -1;
        memStep = -1;
        exStep  = -1;
        wbSrc   = 2'b00;
        expAlu  = 3'b000;
        isSw    = 1'b0;
        aluOk   = 1'b1;

        bus.op = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.Zero = zero;
        bus.LessThan = lt;

        case (op)
            7'b0000011: begin p = '{0, 1, 2, 3, 4}; n = 5; wbStep = 4; wbSrc = 2'b01; memStep = 3; end
            7'b0100011: begin p = '{0, 1, 2, 5, 0}; n = 4; memStep = 3; isSw = 1'b1; end
            7'b0110011: begin
                exStep = 2;
                if (f7 == 7'b0100000) expAlu = 3'b001;
                else if (f3 == 3'b000) expAlu = 3'b000;
                else if (f3 == 3'b111) expAlu = 3'b010;
                else if (f3 == 3'b110) expAlu = 3'b011;
                else if (f3 == 3'b010) expAlu = 3'b101;
                else if (f3 == 3'b011) expAlu = 3'b100;
                else aluOk = 1'b0;
                if (aluOk) begin p = '{0, 1, 6, 8, 0}; n = 4; wbStep = 3; end
                else begin p = '{0, 1, 6, 15, 0}; n = 4; end
            end
            7'b0010011: begin
                exStep = 2;
                if (f3 == 3'b000) expAlu = 3'b000;
                else if (f3 == 3'b100) expAlu = 3'b110;
                else if (f3 == 3'b110) expAlu = 3'b011;
                else if (f3 == 3'b010) expAlu = 3'b101;
                else if (f3 == 3'b011) expAlu = 3'b100;
                else aluOk = 1'b0;
                if (aluOk) begin p = '{0, 1, 7, 8, 0}; n = 4; wbStep = 3; end
                else begin p = '{0, 1, 7, 15, 0}; n = 4; end
            end
            7'b1101111: begin p = '{0, 1, 9, 8, 0}; n = 4; pcStep = 2; wbStep = 3; end
            7'b1100111: begin p = '{0, 1, 10, 11, 8}; n = 5; pcStep = 3; wbStep = 4; end
            7'b1100011: begin
                exStep = 2;
                expAlu = 3'b001;
                if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) begin
                    p = '{0, 1, 12, 0, 0};
                    n = 3;
                    if ((f3 == 3'b000 && zero) || (f3 == 3'b001 && !zero) ||
                        (f3 == 3'b100 && lt) || (f3 == 3'b101 && !lt)) pcStep = 2;
                end else begin
                    p = '{0, 1, 12, 15, 0};
                    n = 4;
                    aluOk = 1'b1;
                end
            end
            7'b0110111: begin p = '{0, 1, 13, 0, 0}; n = 3; wbStep = 2; wbSrc = 2'b11; end
            default: begin p = '{0, 1, 15, 0, 0}; n = 3; end
        endcase

        for (int s = 0; s < n; s++) begin
            if (s == abortStep) begin
                doReset(p[s]);
                return;
            end
            expIr  = (s == 0);
            expPc  = (s == 0) || (s == pcStep);
            expReg = (s == wbStep);
            expMem = isSw && (s == memStep);
            expAdr = (s == memStep);
            @(negedge clk);
            check("state", {28'd0, State}, p[s]);
            check("irwrite", {31'd0, bus.IRWrite}, {31'd0, expIr});
            check("pcwrite", {31'd0, bus.PCWrite}, {31'd0, expPc});
            check("regwrite", {31'd0, bus.RegWrite}, {31'd0, expReg});
            check("memwrite", {31'd0, bus.MemWrite}, {31'd0, expMem});
            check("adrsrc", {31'd0, bus.AdrSrc}, {31'd0, expAdr});
            check("illegal", {31'd0, Illegal}, (p[s] == 15) ? 1 : 0);
            if (s == 0) check("fetch_srcb", {30'd0, bus.ALUSrcB}, 2);
            if (s == 1) check("decode_imm", {29'd0, bus.ImmSrc}, (op == 7'b1100011) ? 2 : 4);
            if (s == exStep && aluOk) check("alu_ctl", {29'd0, bus.ALUControl}, {29'd0, expAlu});
            if (s == wbStep) check("wb_src", {30'd0, bus.ResultSrc}, {30'd0, wbSrc});
            @(posedge clk);
            #1;
        end
        if (p[n-1] != 15) begin
            expCount = (expCount + 1) % CNT_MOD;
            check("instr_count", {28'd0, InstrCount}, expCount);
        end
    endtask

    // ILLEGAL must hold with all enables low
    task automatic holdIllegal(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check("ill_state", {28'd0, State}, 15);
            check("ill_flag", {31'd0, Illegal}, 1);
            check("ill_enables", {28'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}, 0);
            @(posedge clk);
            #1;
        end
    endtask

    // random legal instruction; wide enough to wrap the narrow counter
    task automatic randLegal();
        int cls;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] rTab [5];
        logic [2:0] iTab [5];
        logic [2:0] bTab [4];
        rTab = '{3'b000, 3'b111, 3'b110, 3'b010, 3'b011};
        iTab = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b011};
        bTab = '{3'b000, 3'b001, 3'b100, 3'b101};
        cls = $urandom_range(0, 7);
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'($urandom_range(0, 127));
        case (cls)
            0: runInstr(7'b0000011, f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            1: runInstr(7'b0100011, f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            2: begin
                if ($urandom_range(0, 4) == 0) runInstr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, -1);
                else runInstr(7'b0110011, rTab[$urandom_range(0, 4)], 7'b0000000, 1'b0, 1'b0, -1);
            end
            3: runInstr(7'b0010011, iTab[$urandom_range(0, 4)], f7, 1'b0, 1'b0, -1);
            4: runInstr(7'b1101111, f3, f7, 1'b0, 1'b0, -1);
            5: runInstr(7'b1100111, f3, f7, 1'b0, 1'b0, -1);
            6: runInstr(7'b1100011, bTab[$urandom_range(0, 3)], f7,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            default: runInstr(7'b0110111, f3, f7, 1'b0, 1'b0, -1);
        endcase
    endtask

    // random illegal instruction, then recover through reset
    task automatic randIllegal();
        int cls;
        logic [2:0] rBad [3];
        logic [2:0] iBad [3];
        logic [2:0] bBad [4];
        logic [6:0] opBad [4];
        rBad = '{3'b001, 3'b100, 3'b101};
        iBad = '{3'b001, 3'b101, 3'b111};
        bBad = '{3'b010, 3'b011, 3'b110, 3'b111};
        opBad = '{7'b0000000, 7'b0001111, 7'b1110011, 7'b1010101};
        cls = $urandom_range(0, 3);
        case (cls)
            0: runInstr(7'b0110011, rBad[$urandom_range(0, 2)], 7'b0000000, 1'b0, 1'b0, -1);
            1: runInstr(7'b0010011, iBad[$urandom_range(0, 2)], 7'b0000000, 1'b0, 1'b0, -1);
            2: runInstr(7'b1100011, bBad[$urandom_range(0, 3)], 7'b0000000,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            default: runInstr(opBad[$urandom_range(0, 3)], 3'b000, 7'b0000000, 1'b0, 1'b0, -1);
        endcase
        holdIllegal(3);
        doReset(15);
    endtask

    // directed steps followed by randomized traffic
    initial begin
        checks = 0;
        failures = 0;
        expCount = 0;
        rst = 1'b1;
        bus.op = 7'b0000011;
        bus.funct3 = 3'b000;
        bus.funct7 = 7'b0000000;
        bus.Zero = 1'b0;
        bus.LessThan = 1'b0;
        @(posedge clk);
        #1;
        doReset(0);

        runInstr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, -1);
        runInstr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, -1);
        runInstr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, -1);
        runInstr(7'b0110011, 3'b011, 7'b0000000, 1'b0, 1'b0, -1);
        runInstr(7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0, -1);
        runInstr(7'b1100011, 3'b101, 7'b0000000, 1'b0, 1'b1, -1);
        runInstr(7'b1100111, 3'b000, 7'b0000000, 1'b0, 1'b0, -1);

        for (int k = 0; k < 40; k++) randLegal();

        for (int k = 0; k < 6; k++) begin
            randIllegal();
            randLegal();
        end

        runInstr(7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0, -1);
        holdIllegal(10);
        doReset(15);

        runInstr(7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0, -1);
        runInstr(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b0, -1);
        runInstr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, 3);
        runInstr(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
